// File: rtl/bram_access_ctrl.sv
// bram_access_ctrl: valid/ready request front end for a BRAM wrapper.
// Reads are credit-gated against free slots in the response FIFO, so returned data is never dropped.
module bram_access_ctrl #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 31,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk_a,
  input  logic                  arstz_aq,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  input  logic                  bram_valid,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [4:0]            inflight,
  output logic                  err_unexp
);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [4:0] DEPTH5 = 5'(RSP_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(RSP_DEPTH - 1);
  logic [4:0]            r_inflight, r_fifo_cnt, w_credits;
  logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_mem [RSP_DEPTH];
  logic                  r_err, w_accept, w_rd_acc, w_push, w_pop;
  // A pop frees its credit only from the next edge: credits come from registered counts.
  assign w_credits = DEPTH5 - r_inflight - r_fifo_cnt;
  assign req_ready = arstz_aq & (req_we | (w_credits != '0));
  assign w_accept  = req_valid & req_ready;
  assign w_rd_acc  = w_accept & ~req_we;
  assign w_push    = bram_valid & (r_inflight != '0);
  assign w_pop     = rsp_valid & rsp_ready;
  assign rsp_valid = r_fifo_cnt != '0;
  assign rsp_data  = r_mem[r_rd_ptr];
  assign inflight  = r_inflight;
  assign err_unexp = r_err;
  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) begin
      bram_en    <= 1'b0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_din   <= '0;
      r_inflight <= '0;
      r_fifo_cnt <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_err      <= 1'b0;
      for (int i = 0; i < RSP_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      bram_en    <= w_accept;
      bram_we    <= w_accept & req_we;
      if (w_accept) begin
        bram_addr <= req_addr;
        bram_din  <= req_wdata;
      end
      r_inflight <= r_inflight + {4'd0, w_rd_acc} - {4'd0, w_push};
      r_fifo_cnt <= r_fifo_cnt + {4'd0, w_push} - {4'd0, w_pop};
      if (w_push) begin
        r_mem[r_wr_ptr] <= bram_dout;
        r_wr_ptr        <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + PW'(1);
      if (bram_valid && r_inflight == '0) r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_bram_access_ctrl.sv
// tb_bram_access_ctrl: directed and random stimulus against a queue-based model of request
// issue order, read latency and credit limits, with a behavioural BRAM wrapper attached.
module tb_bram_access_ctrl;
  localparam int AW = 15, DW = 31, DEPTH = 4;
  logic clk_a = 1'b0, arstz_aq = 1'b0, req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0, inj = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic req_ready, bram_en, bram_we, bram_valid, rsp_valid, err_unexp;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din, bram_dout, rsp_data;
  logic [4:0] inflight;
  int checks = 0, errors = 0, ec = 0, pops = 0, accs = 0, lat = 3;
  typedef struct {int t; logic [DW-1:0] d;} ent_t;
  ent_t q[$];
  logic [DW-1:0] ref_mem [16];
  logic [AW-1:0] la = '0;
  logic [DW-1:0] ld = '0;
  logic [DW-1:0] wmem [1<<AW];
  logic [8:1] pv = '0;
  logic [DW-1:0] pd [1:8];

  always #5 clk_a = ~clk_a;

  bram_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(DEPTH)) u_dut (
    .clk_a(clk_a), .arstz_aq(arstz_aq), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .bram_en(bram_en),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout),
    .bram_valid(bram_valid), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .inflight(inflight), .err_unexp(err_unexp));

  // Wrapper: samples en at an edge, returns read data lat edges later; unaffected by the DUT reset.
  always @(posedge clk_a) begin
    pv <= {pv[7:1], bram_en & ~bram_we};
    pd[1] <= wmem[bram_addr];
    for (int i = 2; i <= 8; i++) pd[i] <= pd[i-1];
    if (bram_en & bram_we) wmem[bram_addr] <= bram_din;
  end
  assign bram_valid = pv[lat] | inj;
  assign bram_dout  = pd[lat];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: called at a negedge with inputs set; returns at the following negedge.
  task automatic step();
    int nin;
    logic ev, er, acc, pop;
    #1;
    nin = 0;
    foreach (q[i]) if (q[i].t > ec) nin++;
    ev = q.size() > 0 && q[0].t <= ec;
    er = arstz_aq & (req_we | (q.size() < DEPTH));
    chk("req_ready", {31'd0, req_ready}, {31'd0, er});
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, ev});
    chk("inflight", {27'd0, inflight}, nin);
    if (ev) chk("rsp_data", {1'b0, rsp_data}, {1'b0, q[0].d});
    acc = req_valid & er;
    pop = ev & rsp_ready;
    @(posedge clk_a);
    ec++;
    if (pop) begin
      void'(q.pop_front());
      pops++;
    end
    if (acc) begin
      if (req_we) ref_mem[req_addr[3:0]] = req_wdata;
      else q.push_back('{ec + lat + 1, ref_mem[req_addr[3:0]]});
      la = req_addr;
      ld = req_wdata;
      accs++;
    end
    #1;
    chk("bram_en", {31'd0, bram_en}, {31'd0, acc});
    chk("bram_we", {31'd0, bram_we}, {31'd0, acc & req_we});
    chk("bram_addr", {17'd0, bram_addr}, {17'd0, la});
    chk("bram_din", {1'b0, bram_din}, {1'b0, ld});
    @(negedge clk_a);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, {31'd0, req_ready}, 0);
    chk({tag, "_en"}, {30'd0, bram_en, bram_we}, 0);
    chk({tag, "_addr"}, {17'd0, bram_addr}, 0);
    chk({tag, "_din"}, {1'b0, bram_din}, 0);
    chk({tag, "_rsp"}, {1'b0, rsp_data}, 0);
    chk({tag, "_flags"}, {30'd0, rsp_valid, err_unexp}, 0);
    chk({tag, "_infl"}, {27'd0, inflight}, 0);
  endtask

  initial begin
    int nwait, stalls, a0, p0;
    repeat (4) @(negedge clk_a);
    #1 chk_all_zero("reset");
    @(negedge clk_a);
    arstz_aq = 1'b1;
    repeat (2) step();
    // write 10 <- 12, then read it back at latency 3
    req_valid = 1'b1; req_we = 1'b1; req_addr = 15'd10; req_wdata = 31'd12;
    step();
    req_valid = 1'b0;
    step();
    req_valid = 1'b1; req_we = 1'b0;
    step();
    req_valid = 1'b0; rsp_ready = 1'b1;
    nwait = 0;
    while (!rsp_valid && nwait < 10) begin
      step();
      nwait++;
    end
    chk("rd_latency", nwait, lat + 1);
    chk("rd_data", {1'b0, rsp_data}, 32'd12);
    step();
    // fill the FIFO with rsp_ready low
    rsp_ready = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = AW'(i); req_wdata = DW'(32'h11 * i);
      step();
    end
    req_we = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      req_addr = AW'(i);
      step();
    end
    req_addr = 15'd1;
    repeat (lat + 2) step();
    chk("full_ready", {31'd0, req_ready}, 0);
    chk("full_infl", {27'd0, inflight}, 0);
    chk("full_head", {1'b0, rsp_data}, 32'h11);
    req_valid = 1'b0; rsp_ready = 1'b1;
    step();
    chk("ready_after_pop", {31'd0, req_ready}, 1);
    chk("second_head", {1'b0, rsp_data}, 32'h22);
    repeat (DEPTH + lat + 2) step();
    // streaming at latency 1: DEPTH >= lat+3 sustains one read per cycle
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = AW'(i); req_wdata = DW'($urandom);
      step();
    end
    req_valid = 1'b0;
    repeat (lat + 3) step();
    lat = 1;
    a0 = accs; p0 = pops; stalls = 0;
    req_valid = 1'b1; req_we = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 40 && accs - a0 < 20; i++) begin
      req_addr = AW'($urandom_range(0, 15));
      if (!req_ready) stalls++;
      step();
    end
    req_valid = 1'b0;
    repeat (lat + 4) step();
    chk("stream_accepts", accs - a0, 20);
    chk("stream_stalls", stalls, 0);
    chk("stream_rsps", pops - p0, 20);
    // random traffic at latency 3
    lat = 3;
    for (int i = 0; i < 300; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_we = ($urandom_range(0, 2) == 0);
      req_addr = AW'($urandom_range(0, 15));
      req_wdata = DW'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (DEPTH + lat + 4) step();
    // unexpected return with nothing in flight
    chk("err_before", {31'd0, err_unexp}, 0);
    inj = 1'b1;
    step();
    inj = 1'b0;
    chk("err_set", {31'd0, err_unexp}, 1);
    repeat (2) step();
    chk("err_sticky", {31'd0, err_unexp}, 1);
    // reset with two reads in flight and one buffered
    rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 15'd10;
    repeat (3) step();
    req_valid = 1'b0;
    repeat (2) step();
    chk("pre_rst_infl", {27'd0, inflight}, 2);
    chk("pre_rst_valid", {31'd0, rsp_valid}, 1);
    arstz_aq = 1'b0;
    #1 chk_all_zero("midrst");
    q.delete(); la = '0; ld = '0;
    @(posedge clk_a);
    ec++;
    @(negedge clk_a);
    arstz_aq = 1'b1;
    step();
    chk("late_err", {31'd0, err_unexp}, 1);
    repeat (3) step();
    chk("late_infl", {27'd0, inflight}, 0);
    chk("late_valid", {31'd0, rsp_valid}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
